// File: rtl/mux16_stream_merge.sv
// Two-into-one valid/ready stream merger with a single registered output
// stage. Arbitration is round-robin or forced to one channel; each output
// word carries its source tag, and accepted words are counted per channel.
module mux16_stream_merge #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] A_DATA,
  input  logic             A_VALID,
  output logic             A_READY,
  input  logic [WIDTH-1:0] B_DATA,
  input  logic             B_VALID,
  output logic             B_READY,
  input  logic             SEL_MODE,
  input  logic             SEL,
  output logic [WIDTH-1:0] O_DATA,
  output logic             O_SRC,
  output logic             O_VALID,
  input  logic             O_READY,
  output logic [CNT_W-1:0] A_CNT,
  output logic [CNT_W-1:0] B_CNT
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             src_q, src_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

  logic slot;
  logic grant_a, grant_b;
  logic acc_a, acc_b;

  // The output register can take a word when empty or being drained now.
  assign slot = !vld_q | O_READY;

  // Grant selection: forced mode ignores VALID; round-robin favours the
  // channel that did not win last, falling back to whichever is valid.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (SEL_MODE) begin
      grant_a = !SEL;
      grant_b = SEL;
    end else if (A_VALID && B_VALID) begin
      grant_a = last_q;
      grant_b = !last_q;
    end else begin
      grant_a = A_VALID;
      grant_b = B_VALID;
    end
  end

  assign A_READY = slot & grant_a & !RST;
  assign B_READY = slot & grant_b & !RST;
  assign acc_a   = A_VALID & A_READY;
  assign acc_b   = B_VALID & B_READY;

  // Next state: load on accept, clear valid on a drain with no refill,
  // otherwise hold (covers the stall case).
  always_comb begin
    data_d  = data_q;
    src_d   = src_q;
    vld_d   = vld_q;
    last_d  = last_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (acc_a) begin
      data_d  = A_DATA;
      src_d   = 1'b0;
      vld_d   = 1'b1;
      last_d  = 1'b0;
      a_cnt_d = a_cnt_q + CNT_W'(1);
    end else if (acc_b) begin
      data_d  = B_DATA;
      src_d   = 1'b1;
      vld_d   = 1'b1;
      last_d  = 1'b1;
      b_cnt_d = b_cnt_q + CNT_W'(1);
    end else if (vld_q && O_READY) begin
      vld_d   = 1'b0;
    end
  end

  // State registers; LAST resets to B so A wins the first contended grant.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q  <= '0;
      src_q   <= 1'b0;
      vld_q   <= 1'b0;
      last_q  <= 1'b1;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      data_q  <= data_d;
      src_q   <= src_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign O_DATA  = data_q;
  assign O_SRC   = src_q;
  assign O_VALID = vld_q;
  assign A_CNT   = a_cnt_q;
  assign B_CNT   = b_cnt_q;

endmodule

// File: tb/tb_mux16_stream_merge.sv
// Directed, table-driven bench for mux16_stream_merge plus hand-written
// sequences for counter wrap and asynchronous reset during a stall.
module tb_mux16_stream_merge;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] A_DATA = '0;
  logic        A_VALID = 1'b0;
  logic        A_READY;
  logic [15:0] B_DATA = '0;
  logic        B_VALID = 1'b0;
  logic        B_READY;
  logic        SEL_MODE = 1'b0;
  logic        SEL = 1'b0;
  logic [15:0] O_DATA;
  logic        O_SRC;
  logic        O_VALID;
  logic        O_READY = 1'b0;
  logic [7:0]  A_CNT;
  logic [7:0]  B_CNT;

  int n_chk  = 0;
  int n_fail = 0;

  mux16_stream_merge #(.WIDTH(16), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST),
    .A_DATA(A_DATA), .A_VALID(A_VALID), .A_READY(A_READY),
    .B_DATA(B_DATA), .B_VALID(B_VALID), .B_READY(B_READY),
    .SEL_MODE(SEL_MODE), .SEL(SEL),
    .O_DATA(O_DATA), .O_SRC(O_SRC), .O_VALID(O_VALID), .O_READY(O_READY),
    .A_CNT(A_CNT), .B_CNT(B_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        av;  logic [15:0] ad;
    logic        bv;  logic [15:0] bd;
    logic        sm;  logic        sl;  logic ordy;
    logic        ear; logic        ebr;
    logic        eov; logic [15:0] eod; logic esrc;
    logic [7:0]  eac; logic [7:0]  ebc;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic av, logic [15:0] ad, logic bv, logic [15:0] bd,
                              logic sm, logic sl, logic ordy, logic ear, logic ebr,
                              logic eov, logic [15:0] eod, logic esrc,
                              logic [7:0] eac, logic [7:0] ebc);
    vec_t v;
    v.av = av; v.ad = ad; v.bv = bv; v.bd = bd;
    v.sm = sm; v.sl = sl; v.ordy = ordy;
    v.ear = ear; v.ebr = ebr;
    v.eov = eov; v.eod = eod; v.esrc = esrc;
    v.eac = eac; v.ebc = ebc;
    return v;
  endfunction

  initial begin
    // single A word after reset
    vt[0]  = mk(1,16'h1234, 0,16'h0000, 0,0,1, 1,0, 1,16'h1234,0, 1,0);
    // lone B word so round-robin contention starts with A
    vt[1]  = mk(0,16'h0000, 1,16'hBBBB, 0,0,1, 0,1, 1,16'hBBBB,1, 1,1);
    // contention: strict A,B alternation
    vt[2]  = mk(1,16'hAAAA, 1,16'hBBBB, 0,0,1, 1,0, 1,16'hAAAA,0, 2,1);
    vt[3]  = mk(1,16'hAAAA, 1,16'hBBBB, 0,0,1, 0,1, 1,16'hBBBB,1, 2,2);
    vt[4]  = mk(1,16'hAAAA, 1,16'hBBBB, 0,0,1, 1,0, 1,16'hAAAA,0, 3,2);
    vt[5]  = mk(1,16'hAAAA, 1,16'hBBBB, 0,0,1, 0,1, 1,16'hBBBB,1, 3,3);
    vt[6]  = mk(1,16'hAAAA, 1,16'hBBBB, 0,0,1, 1,0, 1,16'hAAAA,0, 4,3);
    vt[7]  = mk(1,16'hAAAA, 1,16'hBBBB, 0,0,1, 0,1, 1,16'hBBBB,1, 4,4);
    // backpressure for 4 cycles: held word stable, no readies
    vt[8]  = mk(1,16'h0101, 1,16'h0202, 0,0,0, 0,0, 1,16'hBBBB,1, 4,4);
    vt[9]  = mk(1,16'h0101, 1,16'h0202, 0,0,0, 0,0, 1,16'hBBBB,1, 4,4);
    vt[10] = mk(1,16'h0101, 1,16'h0202, 0,0,0, 0,0, 1,16'hBBBB,1, 4,4);
    vt[11] = mk(1,16'h0101, 1,16'h0202, 0,0,0, 0,0, 1,16'hBBBB,1, 4,4);
    // release: drain and refill in the same cycle
    vt[12] = mk(1,16'h0101, 1,16'h0202, 0,0,1, 1,0, 1,16'h0101,0, 5,4);
    vt[13] = mk(1,16'h0101, 1,16'h0202, 0,0,1, 0,1, 1,16'h0202,1, 5,5);
    // drain with no refill: data/src hold
    vt[14] = mk(0,16'h0000, 0,16'h0000, 0,0,1, 0,0, 0,16'h0202,1, 5,5);
    // forced B, both valid
    vt[15] = mk(1,16'h0A01, 1,16'h0B01, 1,1,1, 0,1, 1,16'h0B01,1, 5,6);
    vt[16] = mk(1,16'h0A02, 1,16'h0B02, 1,1,1, 0,1, 1,16'h0B02,1, 5,7);
    vt[17] = mk(1,16'h0A03, 1,16'h0B03, 1,1,1, 0,1, 1,16'h0B03,1, 5,8);
    vt[18] = mk(1,16'h0A04, 1,16'h0B04, 1,1,1, 0,1, 1,16'h0B04,1, 5,9);
    vt[19] = mk(1,16'h0A05, 1,16'h0B05, 1,1,1, 0,1, 1,16'h0B05,1, 5,10);
    // forced B, only A valid: A still refused, output drains
    vt[20] = mk(1,16'h0A06, 0,16'h0000, 1,1,1, 0,1, 0,16'h0B05,1, 5,10);
    // forced A, both valid
    vt[21] = mk(1,16'h5555, 1,16'h6666, 1,0,1, 1,0, 1,16'h5555,0, 6,10);

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_o_valid", O_VALID, 0);
    chk("rst_o_data",  O_DATA, 0);
    chk("rst_o_src",   O_SRC, 0);
    chk("rst_a_cnt",   A_CNT, 0);
    chk("rst_b_cnt",   B_CNT, 0);
    chk("rst_readies", {A_READY, B_READY}, 0);
    @(negedge CLK);
    RST = 1'b0;

    // table-driven vectors
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      A_VALID = vt[i].av; A_DATA = vt[i].ad;
      B_VALID = vt[i].bv; B_DATA = vt[i].bd;
      SEL_MODE = vt[i].sm; SEL = vt[i].sl; O_READY = vt[i].ordy;
      #1;
      chk($sformatf("v%0d_a_ready", i), A_READY, vt[i].ear);
      chk($sformatf("v%0d_b_ready", i), B_READY, vt[i].ebr);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_o_valid", i), O_VALID, vt[i].eov);
      chk($sformatf("v%0d_o_data", i),  O_DATA,  vt[i].eod);
      chk($sformatf("v%0d_o_src", i),   O_SRC,   vt[i].esrc);
      chk($sformatf("v%0d_a_cnt", i),   A_CNT,   vt[i].eac);
      chk($sformatf("v%0d_b_cnt", i),   B_CNT,   vt[i].ebc);
    end

    // async reset pulse between edges to start the wrap test from zero
    @(negedge CLK);
    A_VALID = 0; B_VALID = 0; SEL_MODE = 0; SEL = 0; O_READY = 1;
    #2 RST = 1'b1;
    #1 RST = 1'b0;
    #1;
    chk("pre_wrap_a_cnt", A_CNT, 0);

    // counter wrap: 257 A words, data in order
    for (int i = 0; i < 257; i++) begin
      @(negedge CLK);
      A_VALID = 1; A_DATA = 16'hC000 + 16'(i);
      @(posedge CLK);
      #1;
      chk($sformatf("wrap_data_%0d", i), O_DATA, 16'hC000 + 16'(i));
    end
    chk("wrap_a_cnt", A_CNT, 1);
    chk("wrap_b_cnt", B_CNT, 0);

    // hold BEEF (from A, so LAST points at A) under stall
    @(negedge CLK);
    A_VALID = 1; A_DATA = 16'hBEEF;
    @(negedge CLK);
    A_VALID = 0; O_READY = 0;
    @(posedge CLK);
    #1;
    chk("stall_o_valid", O_VALID, 1);
    chk("stall_o_data",  O_DATA, 16'hBEEF);

    // async reset mid-stall, with A presenting a word during the pulse
    @(negedge CLK);
    A_VALID = 1; A_DATA = 16'h7777;
    #1;
    chk("stall_a_ready", A_READY, 0);
    #1 RST = 1'b1;
    #1;
    chk("arst_o_valid", O_VALID, 0);
    chk("arst_a_cnt",   A_CNT, 0);
    chk("arst_b_cnt",   B_CNT, 0);
    chk("arst_a_ready", A_READY, 0);
    A_VALID = 0;
    O_READY = 1;
    #1 RST = 1'b0;

    // first contended grant after release goes to A
    @(negedge CLK);
    A_VALID = 1; A_DATA = 16'h1111;
    B_VALID = 1; B_DATA = 16'h2222;
    #1;
    chk("post_rst_a_ready", A_READY, 1);
    chk("post_rst_b_ready", B_READY, 0);
    @(posedge CLK);
    #1;
    chk("post_rst_o_data", O_DATA, 16'h1111);
    chk("post_rst_o_src",  O_SRC, 0);
    chk("post_rst_a_cnt",  A_CNT, 1);
    @(negedge CLK);
    A_VALID = 0; B_VALID = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
